score_entry: RTL and testbench

Manual time-entry block: the inverse of the binary-to-digits display path. The operator keys a 4-digit decimal time (s.ttt, same format as the HEX3..HEX0 readout) one digit at a time using switches and debounced button pulses. On ENTER, the block converts the BCD digits sequentially to a binary millisecond count. The result feeds the high-score register as a preset/target value and the BCD digits drive hex_to_7seg for live echo.

---
 rtl/score_entry.sv | 168 ++++++++++++++++
 tb/tb_score_entry.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_entry.sv
// score_entry: manual time entry. The operator keys four BCD digits (s.ttt),
// one at a time, at a moving cursor. ENTER converts them to a binary
// millisecond count, most significant digit first, one digit per cycle.
//
// Ports:
//   iCLK, iRST_N     clock, asynchronous active-low reset
//   iDIGIT           digit value written by iLOAD
//   iLOAD            write iDIGIT at the cursor (values above 9 are rejected)
//   iNEXT            move the cursor to the next lower digit, wrapping 0->3
//   iENTER           start a conversion
//   iCLEAR           zero the digits, home the cursor, abort any conversion
//   oDIGITS          {secs, tenths, hundredths, thousandths}
//   oCURSOR          digit being edited, 3=secs .. 0=thousandths
//   oVALUE           last converted value, clamped to MAX_VALUE
//   oVALID           one-cycle pulse when oVALUE updates
//   oBUSY            high while converting
//   oERR             one-cycle pulse on a rejected digit or a clamped result
module score_entry #(
  parameter int unsigned W         = 14,
  parameter int unsigned MAX_VALUE = 9999
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic [3:0]   iDIGIT,
  input  logic         iLOAD,
  input  logic         iNEXT,
  input  logic         iENTER,
  input  logic         iCLEAR,
  output logic [15:0]  oDIGITS,
  output logic [1:0]   oCURSOR,
  output logic [W-1:0] oVALUE,
  output logic         oVALID,
  output logic         oBUSY,
  output logic         oERR
);

  // Accumulator carries four spare bits so acc*10 + digit never wraps.
  localparam int unsigned AW = W + 4;

  localparam logic [1:0] ST_EDIT    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [AW-1:0] MAX_ACC = AW'(MAX_VALUE);

  logic [1:0]    state_q,  state_d;
  logic [15:0]   digits_q, digits_d;
  logic [1:0]    cursor_q, cursor_d;
  logic [W-1:0]  value_q,  value_d;
  logic          valid_q,  valid_d;
  logic          busy_q,   busy_d;
  logic          err_q,    err_d;
  logic [AW-1:0] acc_q,    acc_d;
  logic [1:0]    idx_q,    idx_d;

  logic [3:0]    digit_sel;
  logic [AW-1:0] acc_mul;

  // Multiply-by-ten as a shift-and-add, then fold in the current digit.
  always_comb begin
    digit_sel = digits_q[{idx_q, 2'b00} +: 4];
    acc_mul   = (acc_q << 3) + (acc_q << 1) + AW'(digit_sel);
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cursor_d = cursor_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    err_d    = 1'b0;
    acc_d    = acc_q;
    idx_d    = idx_q;

    case (state_q)
      ST_EDIT: begin
        if (iENTER) begin
          state_d = ST_CONVERT;
          acc_d   = '0;
          idx_d   = 2'd3;
          busy_d  = 1'b1;
        end else begin
          // Load targets the current cursor even when iNEXT moves it this edge.
          if (iLOAD) begin
            if (iDIGIT <= 4'd9) begin
              for (int i = 0; i < 4; i++) begin
                if (cursor_q == 2'(i)) digits_d[i*4 +: 4] = iDIGIT;
              end
            end else begin
              err_d = 1'b1;
            end
          end
          if (iNEXT) cursor_d = cursor_q - 2'd1;
        end
      end
      ST_CONVERT: begin
        acc_d = acc_mul;
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          if (acc_mul > MAX_ACC) begin
            value_d = W'(MAX_VALUE);
            err_d   = 1'b1;
          end else begin
            value_d = W'(acc_mul);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_EDIT;
      end
      default: begin
        state_d = ST_EDIT;
        busy_d  = 1'b0;
      end
    endcase

    // Clear wins over everything; an aborted conversion leaves oVALUE alone.
    if (iCLEAR) begin
      state_d  = ST_EDIT;
      digits_d = '0;
      cursor_d = 2'd3;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      err_d    = 1'b0;
      acc_d    = '0;
      idx_d    = 2'd3;
      value_d  = value_q;
    end
  end

  // State and output registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= ST_EDIT;
      digits_q <= '0;
      cursor_q <= 2'd3;
      value_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      idx_q    <= 2'd3;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cursor_q <= cursor_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
    end
  end

  assign oDIGITS = digits_q;
  assign oCURSOR = cursor_q;
  assign oVALUE  = value_q;
  assign oVALID  = valid_q;
  assign oBUSY   = busy_q;
  assign oERR    = err_q;

endmodule

// File: tb/tb_score_entry.sv
// Bench for score_entry: a default instance (MAX_VALUE=9999) and a second
// instance clamped at 5000 share one stimulus stream. Expected results are
// queued at ENTER and checked by an independent monitor on oVALID.
module tb_score_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  digit;
  logic        load, nxt, enter, clr;

  logic [15:0] digits1, digits2;
  logic [1:0]  cursor1, cursor2;
  logic [13:0] value1, value2;
  logic        valid1, valid2, busy1, busy2, err1, err2;

  score_entry u_dut (
    .iCLK(clk), .iRST_N(rst_n), .iDIGIT(digit), .iLOAD(load), .iNEXT(nxt),
    .iENTER(enter), .iCLEAR(clr), .oDIGITS(digits1), .oCURSOR(cursor1),
    .oVALUE(value1), .oVALID(valid1), .oBUSY(busy1), .oERR(err1)
  );

  score_entry #(.W(14), .MAX_VALUE(5000)) u_dut5k (
    .iCLK(clk), .iRST_N(rst_n), .iDIGIT(digit), .iLOAD(load), .iNEXT(nxt),
    .iENTER(enter), .iCLEAR(clr), .oDIGITS(digits2), .oCURSOR(cursor2),
    .oVALUE(value2), .oVALID(valid2), .oBUSY(busy2), .oERR(err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v1;
    int e1;
    int v2;
    int e2;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   md[4];          // model digits, index 3 = secs
  int   mcur;
  int   last1, last2;
  int   exp_err_pulses = 0;
  int   got_err_pulses = 0;
  int   busy_run = 0;
  int   prev_run = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] mdig();
    return {4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0])};
  endfunction

  // Monitor: pops the scoreboard whenever the default instance reports a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy1) busy_run++;
      else begin
        if (busy_run != 0) prev_run = busy_run;
        busy_run = 0;
      end
      if (err1 && !valid1) got_err_pulses++;
      if (valid1 || valid2) chk("valid_pair", 32'(valid2), 32'(valid1));
      if (valid1) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got value %0d, expected no result at %0t", value1, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("value", 32'(value1), 32'(e.v1));
          chk("err_at_valid", 32'(err1), 32'(e.e1));
          chk("value_5k", 32'(value2), 32'(e.v2));
          chk("err_at_valid_5k", 32'(err2), 32'(e.e2));
          chk("busy_cycles", 32'(prev_run), 32'd4);
        end
      end
    end
  end

  // Apply one cycle of inputs, sampled at the next rising edge.
  task automatic drive(input bit l, input bit n, input bit e, input bit c, input logic [3:0] d);
    digit = d; load = l; nxt = n; enter = e; clr = c;
    @(posedge clk);
    #1;
    load = 1'b0; nxt = 1'b0; enter = 1'b0; clr = 1'b0;
  endtask

  task automatic chk_edit_state();
    chk("digits", 32'(digits1), 32'(mdig()));
    chk("cursor", 32'(cursor1), 32'(mcur));
  endtask

  task automatic edit(input bit l, input bit n, input logic [3:0] d);
    bit bad;
    bad = l && (d > 4'd9);
    if (l && !bad) md[mcur] = int'(d);
    if (bad) exp_err_pulses++;
    if (n) mcur = (mcur + 3) % 4;
    drive(l, n, 1'b0, 1'b0, d);
    @(negedge clk);
    chk_edit_state();
    if (bad) chk("err_reject", 32'(err1), 32'd1);
  endtask

  task automatic clear_op(input bit l, input logic [3:0] d);
    drive(l, 1'b0, 1'b0, 1'b1, d);
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcur = 3;
    @(negedge clk);
    chk_edit_state();
    chk("busy_after_clear", 32'(busy1), 32'd0);
    chk("err_after_clear", 32'(err1), 32'd0);
    chk("value_held", 32'(value1), 32'(last1));
  endtask

  function automatic exp_t expect_for_model();
    exp_t e;
    int v;
    v = md[3] * 1000 + md[2] * 100 + md[1] * 10 + md[0];
    e.v1 = (v > 9999) ? 9999 : v;
    e.e1 = (v > 9999) ? 1 : 0;
    e.v2 = (v > 5000) ? 5000 : v;
    e.e2 = (v > 5000) ? 1 : 0;
    return e;
  endfunction

  // ENTER, optionally with noise on the editing inputs, then wait for the result.
  task automatic do_enter(input bit noise);
    exp_t e;
    bit   seen;
    int   lat;
    e = expect_for_model();
    q.push_back(e);
    drive(noise, noise, 1'b1, 1'b0, 4'($urandom_range(0, 9)));
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (valid1) begin
        seen = 1'b1;
        lat  = n;
      end else if (noise && n <= 4) begin
        digit = 4'($urandom_range(0, 15));
        load  = 1'($urandom);
        nxt   = 1'($urandom);
        enter = 1'($urandom);
      end
    end
    load = 1'b0; nxt = 1'b0; enter = 1'b0;
    chk("valid_latency", 32'(lat), 32'd5);
    chk_edit_state();
    last1 = e.v1;
    last2 = e.v2;
    @(negedge clk);
    chk("valid_drop", 32'(valid1), 32'd0);
    chk("err_drop", 32'(err1), 32'd0);
    chk("value_hold", 32'(value1), 32'(last1));
  endtask

  task automatic set_all(input int a, input int b, input int c, input int d);
    clear_op(1'b0, 4'd0);
    edit(1'b1, 1'b1, 4'(a));
    edit(1'b1, 1'b1, 4'(b));
    edit(1'b1, 1'b1, 4'(c));
    edit(1'b1, 1'b1, 4'(d));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits"}, 32'(digits1), 32'd0);
    chk({tag, "_cursor"}, 32'(cursor1), 32'd3);
    chk({tag, "_value"}, 32'(value1), 32'd0);
    chk({tag, "_valid"}, 32'(valid1), 32'd0);
    chk({tag, "_busy"}, 32'(busy1), 32'd0);
    chk({tag, "_err"}, 32'(err1), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    digit = 4'd0; load = 1'b0; nxt = 1'b0; enter = 1'b0; clr = 1'b0;
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcur = 3; last1 = 0; last2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    // 1,2,3,4 with separate NEXT pulses; final NEXT wraps cursor to 3.
    edit(1'b1, 1'b0, 4'd1); edit(1'b0, 1'b1, 4'd0);
    edit(1'b1, 1'b0, 4'd2); edit(1'b0, 1'b1, 4'd0);
    edit(1'b1, 1'b0, 4'd3); edit(1'b0, 1'b1, 4'd0);
    edit(1'b1, 1'b0, 4'd4); edit(1'b0, 1'b1, 4'd0);
    chk("digits_1234", 32'(digits1), 32'h1234);
    chk("cursor_wrapped", 32'(cursor1), 32'd3);
    do_enter(1'b0);

    // Rejected digit, then load+next together.
    edit(1'b1, 1'b0, 4'hC);
    edit(1'b1, 1'b1, 4'd7);
    chk("secs_7", 32'(digits1[15:12]), 32'd7);
    chk("cursor_2", 32'(cursor1), 32'd2);

    // Abort a conversion of 0456 two cycles after ENTER.
    set_all(0, 4, 5, 6);
    q.push_back(expect_for_model());
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    chk("busy_started", 32'(busy1), 32'd1);
    @(negedge clk);
    void'(q.pop_back());
    clear_op(1'b0, 4'd0);
    chk("value_kept_1234", 32'(value1), 32'd1234);
    repeat (8) @(negedge clk);

    // Saturation at 9999 (no clamp) and 5000 (clamp + err).
    set_all(9, 9, 9, 9);
    do_enter(1'b0);

    // Editing inputs toggled during conversion are ignored.
    set_all(3, 0, 7, 2);
    do_enter(1'b1);

    // Randomized editing, clearing and conversion.
    for (int it = 0; it < 80; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 3)      edit(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      else if (op == 4) edit(1'b0, 1'b1, 4'd0);
      else if (op == 5) edit(1'b1, 1'b1, 4'($urandom_range(0, 11)));
      else if (op == 6) clear_op(1'($urandom), 4'($urandom_range(10, 15)));
      else              do_enter(1'($urandom));
    end

    // Asynchronous reset in the middle of a conversion.
    set_all(8, 1, 2, 5);
    q.push_back(expect_for_model());
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    q.delete();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcur = 3; last1 = 0; last2 = 0;
    busy_run = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_enter(1'b0);
    chk("zero_result", 32'(value1), 32'd0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("reject_err_pulses", 32'(got_err_pulses), 32'(exp_err_pulses));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
